// File: rtl/node_rx_frame_buffer_if.sv
// Interface bundling the node receive front-end bus.
//   master : local core/network side (drives ids, packets, pop, err_clr)
//   slave  : node_rx_frame_buffer (drives FIFO head, level, status and errors)
interface node_rx_frame_buffer_if #(
  parameter int unsigned NODE_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned PKT_W = NODE_W + DATA_W;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [NODE_W-1:0] node_id;
  logic [NODE_W-1:0] max_node;
  logic [PKT_W-1:0]  control_rx_packet;
  logic [PKT_W-1:0]  data_rx_packet;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic [NODE_W-1:0] rd_src;
  logic              rd_valid;
  logic [LVL_W-1:0]  level;
  logic              busy;
  logic              frame_done;
  logic              err_overflow;
  logic              err_timeout;

  modport master (
    output node_id, max_node, control_rx_packet, data_rx_packet, rd_en, err_clr,
    input  rd_data, rd_src, rd_valid, level, busy, frame_done, err_overflow, err_timeout
  );

  modport slave (
    input  node_id, max_node, control_rx_packet, data_rx_packet, rd_en, err_clr,
    output rd_data, rd_src, rd_valid, level, busy, frame_done, err_overflow, err_timeout
  );
endinterface

// File: rtl/node_rx_frame_buffer.sv
// Receive front-end: accepts a control packet announcing {src,count}, captures
// count data words from that source into a first-word-fall-through FIFO and
// presents them to the core through a valid/ready pop.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : slave modport (packets, ids, pop, err_clr in; head word,
//              level, busy, frame_done, sticky error flags out)
module node_rx_frame_buffer #(
  parameter int unsigned NODE_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  node_rx_frame_buffer_if.slave bus
);
  localparam int unsigned PKT_W = NODE_W + DATA_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_RECV} state_e;

  state_e             state_q, state_d;
  logic [NODE_W-1:0]  src_q, src_d;
  logic [DATA_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]  wcnt_q, wcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PKT_W-1:0]   head_q, head_d;
  logic               rd_valid_q, rd_valid_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_tmo_q, err_tmo_d;
  logic [PKT_W-1:0]   mem_q [DEPTH];

  logic               acc, push, pop, full, ovf_set, tmo_set, ctrl_ok;
  logic [NODE_W-1:0]  ctrl_src, data_src;
  logic [DATA_W-1:0]  ctrl_cnt;

  assign ctrl_src = bus.control_rx_packet[PKT_W-1:DATA_W];
  assign ctrl_cnt = bus.control_rx_packet[DATA_W-1:0];
  assign data_src = bus.data_rx_packet[PKT_W-1:DATA_W];

  // Legal announcement: nonzero count from a valid remote node.
  assign ctrl_ok = (ctrl_cnt != '0) && (ctrl_src != '0) &&
                   (ctrl_src <= bus.max_node) && (ctrl_src != bus.node_id);

  // Next-state, frame tracking and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    tmo_d        = tmo_q;
    frame_done_d = 1'b0;
    tmo_set      = 1'b0;
    acc          = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d  = '0;
        wcnt_d = '0;
        if (ctrl_ok) begin
          src_d   = ctrl_src;
          cnt_d   = ctrl_cnt;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if ((bus.data_rx_packet != '0) && (data_src == src_q)) begin
          acc   = 1'b1;
          tmo_d = '0;
          if (wcnt_q == cnt_q - DATA_W'(1)) begin
            frame_done_d = 1'b1;
            wcnt_d       = '0;
            state_d      = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + DATA_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // This edge completes the TIMEOUT-th idle cycle.
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    full    = (level_q == LVL_W'(DEPTH));
    pop     = bus.rd_en && (level_q != '0);
    // A pop on the same edge frees the slot, so push is legal even when full.
    push    = acc && (!full || pop);
    ovf_set = acc && full && !pop;

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Registered head: bypass the incoming word when it lands at the new head.
    if (level_d == '0) begin
      head_d = '0;
    end else if (push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = bus.data_rx_packet;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    rd_valid_d = (level_d != '0);
    busy_d     = (state_d == S_RECV);
    // A coinciding error event wins over err_clr.
    err_ovf_d  = (err_ovf_q && !bus.err_clr) || ovf_set;
    err_tmo_d  = (err_tmo_q && !bus.err_clr) || tmo_set;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      tmo_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      head_q       <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      tmo_q        <= tmo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      head_q       <= head_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_ovf_q    <= err_ovf_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  // FIFO storage; contents are only observed through head_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_rx_packet;
    end
  end

  assign bus.rd_data      = head_q[DATA_W-1:0];
  assign bus.rd_src       = head_q[PKT_W-1:DATA_W];
  assign bus.rd_valid     = rd_valid_q;
  assign bus.level        = level_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_timeout  = err_tmo_q;
endmodule

// File: tb/tb_node_rx_frame_buffer.sv
// Directed bench for node_rx_frame_buffer (NODE_W=16, DATA_W=16, DEPTH=8, TIMEOUT=64).
module tb_node_rx_frame_buffer;
  localparam int unsigned NODE_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  node_rx_frame_buffer_if #(.NODE_W(NODE_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  node_rx_frame_buffer #(
    .NODE_W(NODE_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ctrl(input logic [31:0] p);
    bus.control_rx_packet = p;
    tick();
    bus.control_rx_packet = '0;
  endtask

  task automatic send_data(input logic [31:0] p);
    bus.data_rx_packet = p;
    tick();
    bus.data_rx_packet = '0;
  endtask

  task automatic test_reset();
    bus.node_id = 16'd1; bus.max_node = 16'd4;
    bus.control_rx_packet = '0; bus.data_rx_packet = '0;
    bus.rd_en = 1'b0; bus.err_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.rd_valid, bus.busy, bus.frame_done, bus.err_overflow, bus.err_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.rd_valid, bus.busy, bus.frame_done, bus.err_overflow, bus.err_timeout});
    end
    n_checks++;
    if ({bus.level, bus.rd_data, bus.rd_src} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: level=%0d rd_data=%h rd_src=%h expected all 0",
               bus.level, bus.rd_data, bus.rd_src);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp_w [4];
    exp_w = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    send_ctrl(32'h0002_0004);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_on: got %b expected 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      send_data({16'h0002, exp_w[i]});
      if (i < 3) begin
        n_checks++;
        if (bus.frame_done !== 1'b0) begin
          n_fail++; $display("FAIL basic_early_done%0d: got %b expected 0", i, bus.frame_done);
        end
      end
    end
    n_checks++;
    if ({bus.frame_done, bus.busy} !== 2'b10) begin
      n_fail++; $display("FAIL basic_done: frame_done,busy=%b expected 10", {bus.frame_done, bus.busy});
    end
    n_checks++;
    if (bus.level !== 4'd4) begin n_fail++; $display("FAIL basic_level: got %0d expected 4", bus.level); end
    n_checks++;
    if (bus.rd_src !== 16'h0002) begin n_fail++; $display("FAIL basic_src: got %h expected 0002", bus.rd_src); end
    tick();
    n_checks++;
    if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", bus.frame_done); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp_w[i]}) begin
        n_fail++; $display("FAIL basic_pop%0d: valid=%b data=%h expected 1 %h", i, bus.rd_valid, bus.rd_data, exp_w[i]);
      end
      tick();
    end
    bus.rd_en = 1'b0;
    n_checks++;
    if ({bus.rd_valid, bus.level} !== 5'b0) begin
      n_fail++; $display("FAIL basic_empty: valid=%b level=%0d expected 0 0", bus.rd_valid, bus.level);
    end
  endtask

  task automatic test_src_filter();
    logic [15:0] exp_w [3];
    exp_w = '{16'h0011, 16'h0022, 16'h0033};
    send_ctrl(32'h0002_0003);
    send_data(32'h0002_0011);
    send_data(32'h0003_0055);
    send_data(32'h0002_0022);
    n_checks++;
    if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL filter_early_done: got %b expected 0", bus.frame_done); end
    send_data(32'h0002_0033);
    n_checks++;
    if ({bus.frame_done, bus.level} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL filter_done: frame_done=%b level=%0d expected 1 3", bus.frame_done, bus.level);
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.rd_data !== exp_w[i]) begin
        n_fail++; $display("FAIL filter_pop%0d: got %h expected %h", i, bus.rd_data, exp_w[i]);
      end
      tick();
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_illegal_ctrl();
    logic [31:0] pk [3];
    pk = '{32'h0001_0002, 32'h0005_0002, 32'h0002_0000};
    for (int i = 0; i < 3; i++) begin
      send_ctrl(pk[i]);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy%0d: got %b expected 0", i, bus.busy); end
    end
    send_data(32'h0002_0077);
    n_checks++;
    if (bus.level !== 4'd0) begin n_fail++; $display("FAIL illegal_idle_data: level=%0d expected 0", bus.level); end
  endtask

  task automatic test_overflow();
    send_ctrl(32'h0002_000A);
    for (int i = 0; i < 10; i++) begin
      send_data({16'h0002, 16'(i + 1)});
      if (i == 7) begin
        n_checks++;
        if ({bus.level, bus.err_overflow} !== {4'd8, 1'b0}) begin
          n_fail++; $display("FAIL ovf_full: level=%0d err=%b expected 8 0", bus.level, bus.err_overflow);
        end
      end
      if (i == 8) begin
        n_checks++;
        if ({bus.level, bus.err_overflow, bus.frame_done} !== {4'd8, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL ovf_set: level=%0d err=%b done=%b expected 8 1 0",
                             bus.level, bus.err_overflow, bus.frame_done);
        end
      end
    end
    n_checks++;
    if ({bus.frame_done, bus.level} !== {1'b1, 4'd8}) begin
      n_fail++; $display("FAIL ovf_done: frame_done=%b level=%0d expected 1 8", bus.frame_done, bus.level);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++;
    if (bus.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", bus.err_overflow); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.rd_data !== 16'(i + 1)) begin
        n_fail++; $display("FAIL ovf_pop%0d: got %h expected %h", i, bus.rd_data, 16'(i + 1));
      end
      tick();
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_timeout();
    send_ctrl(32'h0002_0004);
    send_data(32'h0002_0021);
    send_data(32'h0002_0022);
    repeat (TIMEOUT - 1) tick();
    n_checks++;
    if ({bus.err_timeout, bus.busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_early: err,busy=%b expected 01", {bus.err_timeout, bus.busy});
    end
    tick();
    n_checks++;
    if ({bus.err_timeout, bus.busy, bus.frame_done, bus.level} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
      n_fail++; $display("FAIL tmo_fire: err=%b busy=%b done=%b level=%0d expected 1 0 0 2",
                         bus.err_timeout, bus.busy, bus.frame_done, bus.level);
    end
    send_ctrl(32'h0003_0001);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL tmo_next_ctrl: busy=%b expected 1", bus.busy); end
    send_data(32'h0003_0099);
    n_checks++;
    if ({bus.frame_done, bus.level} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL tmo_next_frame: done=%b level=%0d expected 1 3", bus.frame_done, bus.level);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++;
    if ({bus.err_timeout, bus.rd_data} !== {1'b0, 16'h0021}) begin
      n_fail++; $display("FAIL tmo_clr: err=%b head=%h expected 0 0021", bus.err_timeout, bus.rd_data);
    end
    bus.rd_en = 1'b1;
    repeat (3) tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.level !== 4'd0) begin n_fail++; $display("FAIL tmo_drain: level=%0d expected 0", bus.level); end
  endtask

  task automatic test_full_push_pop_and_reset();
    send_ctrl(32'h0002_000C);
    for (int i = 0; i < 8; i++) send_data({16'h0002, 16'(16'h0100 + i)});
    bus.rd_en = 1'b1;
    send_data(32'h0002_0108);
    n_checks++;
    if ({bus.level, bus.err_overflow, bus.rd_data} !== {4'd8, 1'b0, 16'h0101}) begin
      n_fail++; $display("FAIL pp_full1: level=%0d err=%b head=%h expected 8 0 0101",
                         bus.level, bus.err_overflow, bus.rd_data);
    end
    send_data(32'h0002_0109);
    n_checks++;
    if ({bus.level, bus.err_overflow, bus.rd_data, bus.busy} !== {4'd8, 1'b0, 16'h0102, 1'b1}) begin
      n_fail++; $display("FAIL pp_full2: level=%0d err=%b head=%h busy=%b expected 8 0 0102 1",
                         bus.level, bus.err_overflow, bus.rd_data, bus.busy);
    end
    bus.rd_en = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.rd_valid, bus.busy, bus.frame_done, bus.err_overflow, bus.err_timeout,
         bus.level, bus.rd_data, bus.rd_src} !== '0) begin
      n_fail++; $display("FAIL pp_async_reset: valid=%b busy=%b level=%0d data=%h src=%h expected all 0",
                         bus.rd_valid, bus.busy, bus.level, bus.rd_data, bus.rd_src);
    end
    tick();
    rst = 1'b1;
    send_data(32'h0002_00AA);
    n_checks++;
    if ({bus.level, bus.busy} !== 5'b0) begin
      n_fail++; $display("FAIL pp_after_reset: level=%0d busy=%b expected 0 0", bus.level, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_src_filter();
    test_illegal_ctrl();
    test_overflow();
    test_timeout();
    test_full_push_pop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
